// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: write-back request/grant bundle between two requesters and the register file write port
//   enable                      global advance (0 freezes grants)
//   req{0,1}_valid/addr/data    requester write requests (0 = ALU, 1 = load)
//   req{0,1}_ready              slot can accept this cycle
//   wr_en/wr_addr/wr_data       registered register file write stage
//   pc_write                    write stage targets the top register (R15)
//   busy                        per-register pending-write scoreboard
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic                   enable;
    logic                   req0_valid;
    logic [ADDR_W-1:0]      req0_addr;
    logic [DATA_W-1:0]      req0_data;
    logic                   req0_ready;
    logic                   req1_valid;
    logic [ADDR_W-1:0]      req1_addr;
    logic [DATA_W-1:0]      req1_data;
    logic                   req1_ready;
    logic                   wr_en;
    logic [ADDR_W-1:0]      wr_addr;
    logic [DATA_W-1:0]      wr_data;
    logic                   pc_write;
    logic [2**ADDR_W-1:0]   busy;

    modport master (
        output enable, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_addr, wr_data, pc_write, busy
    );

    modport slave (
        input  enable, req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready, wr_en, wr_addr, wr_data, pc_write, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares one register file write port between ALU and load write-back
//   clk   rising-edge clock
//   rst   asynchronous active-high reset, discards pending writes
//   bus   slave side of regfile_write_arbiter_if (requests in, write stage and busy scoreboard out)
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input logic clk,
    input logic rst,
    regfile_write_arbiter_if.slave bus
);
    localparam int NREG = 2**ADDR_W;

    logic              v0, v1, age, last;
    logic [ADDR_W-1:0] a0, a1, wr_addr;
    logic [DATA_W-1:0] d0, d1, wr_data;
    logic              wr_en, pc_write;
    logic              g0, g1, gnt, acc0, acc1, stay0, stay1;
    logic [ADDR_W-1:0] ga;
    logic [DATA_W-1:0] gd;

    // Same destination: older slot first keeps program order; otherwise alternate.
    always_comb begin
        g0    = bus.enable & v0 & (~v1 | ((a0 == a1) ? ~age : last));
        g1    = bus.enable & v1 & ~g0;
        gnt   = g0 | g1;
        acc0  = bus.req0_valid & (~v0 | g0);
        acc1  = bus.req1_valid & (~v1 | g1);
        stay0 = v0 & ~g0;
        stay1 = v1 & ~g1;
        ga    = g0 ? a0 : a1;
        gd    = g0 ? d0 : d1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v0       <= 1'b0;
            v1       <= 1'b0;
            a0       <= '0;
            a1       <= '0;
            d0       <= '0;
            d1       <= '0;
            age      <= 1'b0;
            last     <= 1'b1;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            pc_write <= 1'b0;
        end else begin
            if (acc0) begin
                v0 <= 1'b1;
                a0 <= bus.req0_addr;
                d0 <= bus.req0_data;
            end else if (g0) v0 <= 1'b0;
            if (acc1) begin
                v1 <= 1'b1;
                a1 <= bus.req1_addr;
                d1 <= bus.req1_data;
            end else if (g1) v1 <= 1'b0;
            // The slot that stays behind while the other refills becomes the older one.
            if (acc0 & acc1) age <= 1'b0;
            else if (acc0 & stay1) age <= 1'b1;
            else if (acc1 & stay0) age <= 1'b0;
            wr_en    <= gnt;
            pc_write <= gnt & (ga == '1);
            if (gnt) begin
                wr_addr <= ga;
                wr_data <= gd;
                last    <= g1;
            end
        end
    end

    assign bus.req0_ready = ~v0 | g0;
    assign bus.req1_ready = ~v1 | g1;
    assign bus.wr_en      = wr_en;
    assign bus.wr_addr    = wr_addr;
    assign bus.wr_data    = wr_data;
    assign bus.pc_write   = pc_write;
    assign bus.busy       = (NREG'(v0) << a0) | (NREG'(v1) << a1) | (NREG'(wr_en) << wr_addr);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, latency, R15 flag, freeze and async reset
module tb_regfile_write_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    initial begin
        bus.enable     = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req0_addr  = '0;
        bus.req0_data  = '0;
        bus.req1_valid = 1'b0;
        bus.req1_addr  = '0;
        bus.req1_data  = '0;
        tick;
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready0", 32'(bus.req0_ready), 1);
        chk("rst_ready1", 32'(bus.req1_ready), 1);
        rst = 1'b0;
        // round-robin with both requesters held valid
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd1; bus.req0_data = 32'h11;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd2; bus.req1_data = 32'h22;
        tick;
        chk("rr_accept_wr_en", 32'(bus.wr_en), 0);
        chk("rr_ready0", 32'(bus.req0_ready), 1);
        chk("rr_ready1", 32'(bus.req1_ready), 0);
        chk("rr_busy", 32'(bus.busy), 32'h6);
        tick;
        chk("rr_w1_en", 32'(bus.wr_en), 1);
        chk("rr_w1_addr", 32'(bus.wr_addr), 1);
        chk("rr_w1_data", bus.wr_data, 32'h11);
        tick;
        chk("rr_w2_en", 32'(bus.wr_en), 1);
        chk("rr_w2_addr", 32'(bus.wr_addr), 2);
        chk("rr_w2_data", bus.wr_data, 32'h22);
        tick;
        chk("rr_w3_addr", 32'(bus.wr_addr), 1);
        chk("rr_w3_busy", 32'(bus.busy), 32'h6);
        tick;
        chk("rr_w4_en", 32'(bus.wr_en), 1);
        chk("rr_w4_addr", 32'(bus.wr_addr), 2);
        // async reset mid-transfer with both slots full
        rst = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("arst_wr_en", 32'(bus.wr_en), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_ready0", 32'(bus.req0_ready), 1);
        chk("arst_ready1", 32'(bus.req1_ready), 1);
        chk("arst_pc_write", 32'(bus.pc_write), 0);
        tick;
        rst = 1'b0;
        tick;
        chk("arst_after_wr_en", 32'(bus.wr_en), 0);
        chk("arst_after_busy", 32'(bus.busy), 0);
        // single ALU write latency
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 32'hAA;
        tick;
        bus.req0_valid = 1'b0;
        chk("lat_pend_wr_en", 32'(bus.wr_en), 0);
        chk("lat_pend_busy", 32'(bus.busy), 32'h8);
        tick;
        chk("lat_wr_en", 32'(bus.wr_en), 1);
        chk("lat_wr_addr", 32'(bus.wr_addr), 3);
        chk("lat_wr_data", bus.wr_data, 32'hAA);
        chk("lat_busy", 32'(bus.busy), 32'h8);
        chk("lat_pc_write", 32'(bus.pc_write), 0);
        tick;
        chk("lat_done_wr_en", 32'(bus.wr_en), 0);
        chk("lat_done_busy", 32'(bus.busy), 0);
        chk("lat_hold_addr", 32'(bus.wr_addr), 3);
        chk("lat_hold_data", bus.wr_data, 32'hAA);
        // write to R15 raises pc_write
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd15; bus.req0_data = 32'h100;
        tick;
        bus.req0_valid = 1'b0;
        tick;
        chk("pc_pc_write", 32'(bus.pc_write), 1);
        chk("pc_wr_en", 32'(bus.wr_en), 1);
        chk("pc_wr_addr", 32'(bus.wr_addr), 15);
        chk("pc_wr_data", bus.wr_data, 32'h100);
        chk("pc_busy", 32'(bus.busy), 32'h8000);
        tick;
        chk("pc_clear", 32'(bus.pc_write), 0);
        chk("pc_clear_wr_en", 32'(bus.wr_en), 0);
        // same destination while frozen: load first, then ALU
        bus.enable = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd5; bus.req1_data = 32'h55;
        tick;
        bus.req1_valid = 1'b0;
        chk("frz_ready1", 32'(bus.req1_ready), 0);
        chk("frz_ready0_empty", 32'(bus.req0_ready), 1);
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd5; bus.req0_data = 32'h66;
        tick;
        chk("frz_wr_en", 32'(bus.wr_en), 0);
        chk("frz_busy", 32'(bus.busy), 32'h20);
        chk("frz_ready0", 32'(bus.req0_ready), 0);
        chk("frz_ready1_full", 32'(bus.req1_ready), 0);
        // requests offered to full frozen slots must be ignored
        bus.req0_addr = 4'd7; bus.req0_data = 32'h77;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd8; bus.req1_data = 32'h88;
        tick;
        chk("frz2_wr_en", 32'(bus.wr_en), 0);
        chk("frz2_busy", 32'(bus.busy), 32'h20);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.enable = 1'b1;
        tick;
        chk("age_w1_en", 32'(bus.wr_en), 1);
        chk("age_w1_addr", 32'(bus.wr_addr), 5);
        chk("age_w1_data", bus.wr_data, 32'h55);
        chk("age_w1_busy", 32'(bus.busy), 32'h20);
        tick;
        chk("age_w2_en", 32'(bus.wr_en), 1);
        chk("age_w2_addr", 32'(bus.wr_addr), 5);
        chk("age_w2_data", bus.wr_data, 32'h66);
        tick;
        chk("age_done_wr_en", 32'(bus.wr_en), 0);
        chk("age_done_busy", 32'(bus.busy), 0);
        chk("age_hold_data", bus.wr_data, 32'h66);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
